// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative signed multiply/divide unit with HI/LO result registers
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t             state;
    logic               op_r;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [CNT_W-1:0]   cnt;
    // Multiply: {P_hi, P_lo}; the carry bit lives only in the step sum below.
    logic [2*WIDTH-1:0] acc;
    // Divide: remainder never reaches |b|, so its top bit is implied zero.
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH:0]   mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod_signed;

    always_comb begin
        abs_a       = a[WIDTH-1] ? (~a + 1'b1) : a;
        abs_b       = b[WIDTH-1] ? (~b + 1'b1) : b;
        mul_sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);
        mul_next    = {mul_sum, acc[WIDTH-1:0]} >> 1;
        div_shift   = {rem, quo[WIDTH-1]};
        div_diff    = div_shift - {1'b0, mag_b};
        prod_signed = (sign_a ^ sign_b) ? (~acc + 1'b1) : acc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            op_r     <= 1'b0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            mag_a    <= '0;
            mag_b    <= '0;
            cnt      <= '0;
            acc      <= '0;
            rem      <= '0;
            quo      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (op && (b == '0)) begin
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                        end else begin
                            op_r   <= op;
                            sign_a <= a[WIDTH-1];
                            sign_b <= b[WIDTH-1];
                            mag_a  <= abs_a;
                            mag_b  <= abs_b;
                            cnt    <= '0;
                            acc    <= {{WIDTH{1'b0}}, abs_b};
                            rem    <= '0;
                            quo    <= abs_a;
                            busy   <= 1'b1;
                            state  <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (op_r) begin
                        if (!div_diff[WIDTH]) begin
                            rem <= div_diff[WIDTH-1:0];
                            quo <= {quo[WIDTH-2:0], 1'b1};
                        end else begin
                            rem <= div_shift[WIDTH-1:0];
                            quo <= {quo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc <= mul_next[2*WIDTH-1:0];
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (op_r) begin
                        lo <= (sign_a ^ sign_b) ? (~quo + 1'b1) : quo;
                        hi <= sign_a ? (~rem + 1'b1) : rem;
                    end else begin
                        hi <= prod_signed[2*WIDTH-1:WIDTH];
                        lo <= prod_signed[WIDTH-1:0];
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed-vector bench for mult_div_unit
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int vec_cnt;
    int err_cnt;

    mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called on a falling edge; start is sampled on the next rising edge.
    task automatic issue(input logic o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic wait_done(input int poke, input bit poke_rst,
                             output bit got, output int lat, output int bcnt);
        got  = 1'b0;
        lat  = 0;
        bcnt = 0;
        while (lat < 60) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) bcnt++;
            if (lat == poke) begin
                if (poke_rst) reset = 1'b1;
                else begin
                    start = 1'b1;
                    op    = 1'b1;
                    a     = 32'd9;
                    b     = 32'd3;
                end
            end
            @(negedge clk);
            reset = 1'b0;
            start = 1'b0;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo);
        bit got;
        int lat;
        int bcnt;
        issue(o, x, y);
        wait_done(-1, 1'b0, got, lat, bcnt);
        check({tag, "_done"}, 32'(got), 32'd1);
        check({tag, "_lat"}, 32'(lat), 32'd33);
        check({tag, "_busy_cycles"}, 32'(bcnt), 32'd33);
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
    endtask

    initial begin
        bit got;
        int lat;
        int bcnt;
        bit saw_busy;
        vec_cnt = 0;
        err_cnt = 0;
        reset   = 1'b1;
        start   = 1'b0;
        op      = 1'b0;
        a       = '0;
        b       = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_dz", 32'(div_zero), 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);

        run_op("mul_7_m3", 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        run_op("mul_max", 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001);
        run_op("mul_min", 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_100_m7", 1'b1, 32'd100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2);
        run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

        // 0x451 / 0x20 leaves hi=0x11, lo=0x22 as a known preload
        run_op("preload", 1'b1, 32'h451, 32'h20, 32'h11, 32'h22);
        @(negedge clk);
        issue(1'b1, 32'd55, 32'd0);
        check("dz_done", 32'(done), 32'd1);
        check("dz_flag", 32'(div_zero), 32'd1);
        check("dz_busy", 32'(busy), 32'd0);
        saw_busy = busy;
        @(negedge clk);
        saw_busy = saw_busy | busy;
        check("dz_done_clr", 32'(done), 32'd0);
        check("dz_flag_clr", 32'(div_zero), 32'd0);
        repeat (3) begin
            @(negedge clk);
            saw_busy = saw_busy | busy;
        end
        check("dz_busy_never", 32'(saw_busy), 32'd0);
        check("dz_hi_hold", hi, 32'h11);
        check("dz_lo_hold", lo, 32'h22);

        issue(1'b0, 32'd5, 32'd6);
        wait_done(10, 1'b0, got, lat, bcnt);
        check("ign_done", 32'(got), 32'd1);
        check("ign_lat", 32'(lat), 32'd33);
        check("ign_hi", hi, 32'd0);
        check("ign_lo", lo, 32'd30);

        issue(1'b1, 32'd9, 32'd3);
        wait_done(-1, 1'b0, got, lat, bcnt);
        check("b2b_done", 32'(got), 32'd1);
        check("b2b_lat", 32'(lat), 32'd33);
        check("b2b_hi", hi, 32'd0);
        check("b2b_lo", lo, 32'd3);

        @(negedge clk);
        issue(1'b1, 32'd1000, 32'd3);
        wait_done(15, 1'b1, got, lat, bcnt);
        check("abort_no_done", 32'(got), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);

        run_op("post_rst", 1'b0, 32'd2, 32'd3, 32'd0, 32'd6);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multicycle signed multiply/divide responder for the MIPS datapath; serves MULT (funct 011000) and DIV (funct 011010).
- The control unit raises start and holds its state until done. Results go into internal HI/LO registers, read by the MFHI/MFLO write-back path.
- Iterative: one partial-product or partial-remainder step per cycle, using magnitude arithmetic followed by a sign fix-up.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- op  input  1  0 = MULT, 1 = DIV; sampled with start.
- a  input  WIDTH  rs operand (multiplicand / dividend), two's complement.
- b  input  WIDTH  rt operand (multiplier / divisor), two's complement.
- busy  output  1  high while an operation is in flight.
- done  output  1  single-cycle completion pulse.
- div_zero  output  1  single-cycle pulse; DIV with b == 0.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Interface decided: reset reset, synchronous, active-high; clock clk.
- Reset: state=IDLE; busy=0, done=0, div_zero=0, hi=0, lo=0; counter and working registers cleared.
- Reset mid-operation aborts the operation. No done pulse is issued; hi/lo are forced to 0.
- States: IDLE, CALC, FIX.
- IDLE, start=1, normal case (edge E0):
  - Latch op, the sign bits of a and b, |a| and |b|.
  - counter=0, busy=1, next state CALC.
- IDLE, start=1, op=1, b==0 (edge E0):
  - No calculation; stay in IDLE; busy stays 0.
  - done=1 and div_zero=1 for the following cycle; hi/lo unchanged.
- CALC, MULT: 2*WIDTH+1-bit accumulator {carry, P_hi, P_lo}, with P_lo initialised to |b|. Each cycle:
  - If P_lo[0]=1, add |a| into {carry, P_hi}.
  - Shift the whole accumulator right by 1.
- CALC, DIV: restoring division. Remainder R (WIDTH+1 bits) initialised to 0; Q initialised to |a|. Each cycle:
  - Shift {R, Q} left by 1.
  - If R >= |b|, set R = R - |b| and Q[0]=1.
- CALC exit: after WIDTH iterations (edges E1..E32 for WIDTH=32), go to FIX. Counter counts 0..WIDTH-1.
- FIX (edge E33), MULT: negate the 2*WIDTH product if sign_a XOR sign_b; hi = upper half, lo = lower half.
- FIX (edge E33), DIV:
  - lo = Q, negated if sign_a XOR sign_b.
  - hi = R[WIDTH-1:0], negated if sign_a.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
- FIX always: done=1 for exactly one cycle, busy=0, next state IDLE.
- Latency: done is high in the cycle after E33, i.e. WIDTH+1 edges after the start edge.
- hi/lo change only in FIX or on reset, and hold between operations.
- start while busy=1: ignored; no queueing and no effect on the operation in flight.
- start in the cycle done=1: accepted, since the unit is already in IDLE. Back-to-back operations are legal.
- Overflow case -2^31 / -1: magnitude result 2^31 truncates to lo=0x80000000, hi=0. No exception flag.
- Most-negative operands: magnitude 2^31 fits in the unsigned WIDTH-bit field and needs no special-casing.
- a and b may change after the start edge without affecting the result.

Test Plan:
- Reset, then idle 5 cycles -> busy=0, done=0, div_zero=0, hi=0, lo=0.
- MULT a=7, b=-3 (0xFFFFFFFD) -> done 33 edges after start; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for exactly 33 cycles.
- MULT a=0x7FFFFFFF, b=0x7FFFFFFF -> hi=0x3FFFFFFF, lo=0x00000001.
- MULT a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0x00000000.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=100, b=-7 -> lo=0xFFFFFFF2, hi=0x00000002.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV b=0 with preloaded hi=0x11, lo=0x22 -> next cycle done=1 and div_zero=1 for one cycle; busy never rises; hi/lo remain 0x11/0x22.
- Start MULT 5*6, pulse start with DIV 9/3 at cycle 10 (ignored) -> hi=0, lo=30.
- Immediately after done, start DIV 9/3 -> lo=3, hi=0.
- Start DIV 1000/3, assert reset at cycle 15 for one cycle -> no done pulse; hi=lo=0, busy=0.
- After that reset, MULT 2*3 -> lo=6 after the normal latency.
